// File: rtl/prog_loader_uart.sv
// prog_loader_uart
//   Serial program loader. Receives a framed 8N1 byte stream on rx and writes
//   the payload into the 4096x8 program memory. The processor is held in
//   reset (cpu_hold) while a load runs and after a failed one.
//
//   Frame: SYNC_BYTE, LEN_HI (upper nibble 0), LEN_LO, len+1 data bytes,
//   checksum (8-bit sum of the data bytes).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   rx         UART line, idles high, 8N1, LSB first
//   mem_we     program-memory write strobe, one cycle per data byte
//   mem_addr   program-memory write address (held between writes)
//   mem_wdata  program-memory write data (held between writes)
//   cpu_hold   processor reset: high while loading or after a failed load
//   busy       high from SYNC_BYTE acceptance until checksum evaluation
//   done       sticky: last load completed with a good checksum
//   error      sticky: last load failed (framing, header or checksum)
//
// Internal handshake: byte_valid and frame_err are single-cycle pulses from
// the receiver; the loader consumes them in the cycle they are high, with no
// back-pressure (the loader is always ready).
module prog_loader_uart #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------------
  // rx synchronizer (idles high, so reset to 1)
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s  <= rx_s1;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;

  r_state_t      r_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          byte_valid;
  logic          frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (!rx_s) begin
            cnt     <= HALF;
            r_state <= R_START;
          end
        end
        R_START: begin
          // Re-sample mid start bit; a high line here was a glitch.
          if (cnt == '0) begin
            if (rx_s) begin
              r_state <= R_IDLE;
            end else begin
              cnt     <= FULL;
              bit_idx <= '0;
              r_state <= R_DATA;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (cnt == '0) begin
            shift <= {rx_s, shift[7:1]};
            cnt   <= FULL;
            if (bit_idx == 3'd7) r_state <= R_STOP;
            else                 bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (cnt == '0) begin
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
            r_state <= R_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Loader FSM
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM} l_state_t;

  l_state_t    l_state;
  logic [11:0] len;
  logic [11:0] addr;   // next write address; mem_addr keeps the last one
  logic [7:0]  sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_state   <= L_IDLE;
      len       <= '0;
      addr      <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (l_state == L_IDLE) begin
        // Framing errors between loads are line noise, not a failed load.
        if (byte_valid && shift == SYNC_BYTE) begin
          cpu_hold <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          error    <= 1'b0;
          addr     <= '0;
          sum      <= '0;
          l_state  <= L_LEN_HI;
        end
      end else if (frame_err) begin
        busy     <= 1'b0;
        cpu_hold <= 1'b1;
        error    <= 1'b1;
        l_state  <= L_IDLE;
      end else if (byte_valid) begin
        case (l_state)
          L_LEN_HI: begin
            if (shift[7:4] != 4'h0) begin
              busy     <= 1'b0;
              cpu_hold <= 1'b1;
              error    <= 1'b1;
              l_state  <= L_IDLE;
            end else begin
              len[11:8] <= shift[3:0];
              l_state   <= L_LEN_HI == l_state ? L_LEN_LO : l_state;
            end
          end
          L_LEN_LO: begin
            len[7:0] <= shift;
            l_state  <= L_DATA;
          end
          L_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= shift;
            sum       <= sum + shift;
            addr      <= addr + 1'b1;
            // Exit on the write at address len, before addr could wrap.
            if (addr == len) l_state <= L_CSUM;
          end
          L_CSUM: begin
            busy <= 1'b0;
            if (shift == sum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
            l_state <= L_IDLE;
          end
          default: l_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule
